// File: rtl/inst_mem_responder_if.sv
// Fetch and program-loader signals between a CPU core (or test harness) and
// its instruction memory responder.
interface inst_mem_responder_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  ce_i;
  logic [31:0]           addr_i;
  logic [31:0]           inst_o;
  logic                  stall_req_o;
  logic                  fetch_err_o;
  logic                  load_en_i;
  logic                  load_valid_i;
  logic [7:0]            load_byte_i;
  logic                  load_done_o;
  logic [DEPTH_LOG2:0]   load_words_o;
  logic                  load_ovf_o;

  modport master (
    output ce_i, addr_i, load_en_i, load_valid_i, load_byte_i,
    input  inst_o, stall_req_o, fetch_err_o, load_done_o, load_words_o, load_ovf_o
  );

  modport slave (
    input  ce_i, addr_i, load_en_i, load_valid_i, load_byte_i,
    output inst_o, stall_req_o, fetch_err_o, load_done_o, load_words_o, load_ovf_o
  );
endinterface

// File: rtl/inst_mem_responder.sv
// Word-organised instruction RAM with programmable fetch latency and a
// byte-serial program loader; the memory side of the core's fetch port.
module inst_mem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input logic                clk,
  input logic                rst,
  inst_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_LOAD} state_t;

  state_t              state, state_n;
  logic [3:0]          cnt;
  logic [31:0]         addr_q;
  logic [31:0]         inst_q;
  logic                err_q;
  logic                done_q;
  logic                ovf_q;
  logic [DEPTH_LOG2:0] ptr;
  logic [1:0]          lane;
  logic [23:0]         byte_buf;
  logic [31:0]         mem [1 << DEPTH_LOG2];

  logic                hit;
  logic                accept;
  logic                do_read;
  logic [31:0]         rd_addr;
  logic                load_enter;
  logic                load_exit;
  logic                load_beat;
  logic                wr_en;

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (|a[31:DEPTH_LOG2+2]);
  endfunction

  assign hit        = (state == S_RESP) && (bus.addr_i == addr_q);
  assign load_enter = bus.load_en_i && (state != S_LOAD);
  assign load_exit  = !bus.load_en_i && (state == S_LOAD);
  assign load_beat  = bus.load_en_i && bus.load_valid_i && (state == S_LOAD);
  assign wr_en      = load_beat && (lane == 2'd3) && !ptr[DEPTH_LOG2];

  // Only a served, unchanged address skips the stall; LOAD never serves.
  assign bus.stall_req_o  = !rst && bus.ce_i && !hit;
  assign bus.inst_o       = inst_q;
  assign bus.fetch_err_o  = err_q && (state == S_RESP);
  assign bus.load_done_o  = done_q;
  assign bus.load_words_o = ptr;
  assign bus.load_ovf_o   = ovf_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_n = state;
    accept  = 1'b0;
    do_read = 1'b0;
    rd_addr = addr_q;
    case (state)
      S_IDLE: accept = bus.ce_i;
      S_WAIT: begin
        if (!bus.ce_i) begin
          state_n = S_IDLE;
        end else if (cnt == 4'd1) begin
          do_read = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (!bus.ce_i) state_n = S_IDLE;
        else           accept  = !hit;
      end
      S_LOAD:  if (!bus.load_en_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (accept) begin
      if (WAIT_CYCLES == 0) begin
        do_read = 1'b1;
        rd_addr = bus.addr_i;
        state_n = S_RESP;
      end else begin
        state_n = S_WAIT;
      end
    end

    // The loader pre-empts any fetch in flight.
    if (bus.load_en_i) begin
      state_n = S_LOAD;
      accept  = 1'b0;
      do_read = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      inst_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ptr      <= '0;
      lane     <= '0;
      byte_buf <= '0;
    end else begin
      done_q <= load_exit;

      if (accept) begin
        addr_q <= bus.addr_i;
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (do_read) begin
        if (is_fault(rd_addr)) begin
          inst_q <= NOP_INST;
          err_q  <= 1'b1;
        end else begin
          inst_q <= mem[rd_addr[DEPTH_LOG2+1:2]];
          err_q  <= 1'b0;
        end
      end

      // A fresh session restarts at word 0; a partial word left by the
      // previous session is abandoned because lane restarts at 0.
      if (load_enter) begin
        ptr   <= '0;
        lane  <= '0;
        ovf_q <= 1'b0;
      end else if (load_beat) begin
        lane <= lane + 2'd1;
        if (lane != 2'd3)          byte_buf[{lane, 3'b000} +: 8] <= bus.load_byte_i;
        else if (ptr[DEPTH_LOG2])  ovf_q <= 1'b1;
        else                       ptr   <= ptr + 1'b1;
      end
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto RAM and
  // a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr[DEPTH_LOG2-1:0]] <= {bus.load_byte_i, byte_buf};
  end

endmodule
